// File: rtl/mul_div_unit_if.sv
// EX-stage multiply/divide bus between the controller (master) and mul_div_unit (slave).
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             md_start;
   logic [1:0]       md_op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             hilo_wr;
   logic             hilo_sel;
   logic             md_run;
   logic             md_done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output stall, md_start, md_op, src_a, src_b, hilo_wr, hilo_sel,
      input  md_run, md_done, hi, lo
   );

   modport slave (
      input  stall, md_start, md_op, src_a, src_b, hilo_wr, hilo_sel,
      output md_run, md_done, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Optional MD_FAST_MUL_EN: single-cycle combinational MULT/MULTU; DIV/DIVU stay iterative.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic           clk,
   input  logic           reset,
   mul_div_unit_if.slave  md
);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_a, mag_b, a_raw;
   logic               op_div, q_neg, r_neg, div_zero;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a_c, mag_b_c;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_part;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef MD_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
`endif

   assign accept  = md.md_start & ~md.stall;
   assign a_neg   = ~md.md_op[0] & md.src_a[WIDTH-1];
   assign b_neg   = ~md.md_op[0] & md.src_b[WIDTH-1];
   assign mag_a_c = a_neg ? -md.src_a : md.src_a;
   assign mag_b_c = b_neg ? -md.src_b : md.src_b;

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring divide: when the trial subtraction fits, the result is below the divisor, so W-bit math suffices.
   assign div_part = acc[2*WIDTH-1:WIDTH-1];
   assign div_ge   = (div_part >= {1'b0, mag_b});
   assign div_rem  = div_ge ? (div_part[WIDTH-1:0] - mag_b) : div_part[WIDTH-1:0];
   assign div_next = {div_rem, acc[WIDTH-2:0], div_ge};

`ifdef MD_FAST_MUL_EN
   assign ext_a     = md.md_op[0] ? {{WIDTH{1'b0}}, md.src_a} : {{WIDTH{md.src_a[WIDTH-1]}}, md.src_a};
   assign ext_b     = md.md_op[0] ? {{WIDTH{1'b0}}, md.src_b} : {{WIDTH{md.src_b[WIDTH-1]}}, md.src_b};
   assign fast_prod = ext_a * ext_b;
`endif

   always_comb begin
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = acc[WIDTH-1:0];
      if (op_div) begin
         if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            if (q_neg) res_lo = -acc[WIDTH-1:0];
            if (r_neg) res_hi = -acc[2*WIDTH-1:WIDTH];
         end
      end else if (q_neg) begin
         {res_hi, res_lo} = -acc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = BUSY;
`ifdef MD_FAST_MUL_EN
               if (!md.md_op[1]) state_n = FIXUP;
`endif
            end
         end
         BUSY:    if (cnt == '0) state_n = FIXUP;
         FIXUP:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         acc      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         a_raw    <= '0;
         op_div   <= 1'b0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         div_zero <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_div   <= md.md_op[1];
                  mag_a    <= mag_a_c;
                  mag_b    <= mag_b_c;
                  a_raw    <= md.src_a;
                  q_neg    <= a_neg ^ b_neg;
                  r_neg    <= a_neg;
                  div_zero <= (md.src_b == '0);
                  cnt      <= CNT_W'(WIDTH - 1);
                  acc      <= md.md_op[1] ? {{WIDTH{1'b0}}, mag_a_c} : {{WIDTH{1'b0}}, mag_b_c};
`ifdef MD_FAST_MUL_EN
                  if (!md.md_op[1]) begin
                     acc   <= fast_prod;
                     q_neg <= 1'b0;
                  end
`endif
               end else if (md.hilo_wr && !md.stall) begin
                  if (md.hilo_sel) hi_q <= md.src_a;
                  else             lo_q <= md.src_a;
               end
            end
            BUSY: begin
               acc <= op_div ? div_next : mul_next;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            FIXUP: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign md.md_run  = (state != IDLE);
   assign md.md_done = (state == FIXUP);
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;

endmodule
